// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and default sizes for the I/D memory arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin sharing of one line-wide memory port between the
//               instruction cache (reads) and data cache (reads/writes)
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_icache_read_en,
    input  logic [ADDR_WIDTH-1:0] in_icache_addr,
    output logic [LINE_WIDTH-1:0] out_icache_read_data,
    output logic                  out_icache_ready,
    input  logic                  in_dcache_read_en,
    input  logic                  in_dcache_write_en,
    input  logic [ADDR_WIDTH-1:0] in_dcache_addr,
    input  logic [LINE_WIDTH-1:0] in_dcache_write_data,
    output logic [LINE_WIDTH-1:0] out_dcache_read_data,
    output logic                  out_dcache_ready,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [LINE_WIDTH-1:0] out_mem_write_data,
    input  logic [LINE_WIDTH-1:0] in_mem_read_data,
    input  logic                  in_mem_ready
);

    arb_state_t r_state;
    requester_t r_grant;
    requester_t r_last_grant;
    op_t        r_op;
    logic       r_mask;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_d;

    // The requester served last is blind for one IDLE cycle so a stale held
    // enable cannot win a second transaction.
    always_comb begin
        w_req_i  = in_icache_read_en &&
                   !(r_mask && (r_last_grant == REQ_I));
        w_req_d  = (in_dcache_read_en || in_dcache_write_en) &&
                   !(r_mask && (r_last_grant == REQ_D));
        w_pick_d = w_req_d && (!w_req_i || (r_last_grant == REQ_I));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state              <= IDLE;
            r_grant              <= REQ_I;
            r_last_grant         <= REQ_D;
            r_op                 <= OP_READ;
            r_mask               <= 1'b0;
            out_icache_read_data <= '0;
            out_icache_ready     <= 1'b0;
            out_dcache_read_data <= '0;
            out_dcache_ready     <= 1'b0;
            out_mem_read_en      <= 1'b0;
            out_mem_write_en     <= 1'b0;
            out_mem_addr         <= '0;
            out_mem_write_data   <= '0;
        end else begin
            out_mem_read_en  <= 1'b0;
            out_mem_write_en <= 1'b0;
            out_icache_ready <= 1'b0;
            out_dcache_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mask <= 1'b0;
                    if (w_req_i || w_req_d) begin
                        r_state <= ISSUE;
                        if (w_pick_d) begin
                            // A write wins when both D enables are high.
                            r_grant            <= REQ_D;
                            r_op               <= in_dcache_write_en ? OP_WRITE : OP_READ;
                            out_mem_addr       <= in_dcache_addr;
                            out_mem_write_data <= in_dcache_write_en ? in_dcache_write_data : '0;
                            out_mem_read_en    <= !in_dcache_write_en;
                            out_mem_write_en   <= in_dcache_write_en;
                        end else begin
                            r_grant            <= REQ_I;
                            r_op               <= OP_READ;
                            out_mem_addr       <= in_icache_addr;
                            out_mem_write_data <= '0;
                            out_mem_read_en    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (in_mem_ready) begin
                        r_state <= RESP;
                        if (r_grant == REQ_I) begin
                            out_icache_read_data <= in_mem_read_data;
                            out_icache_ready     <= 1'b1;
                        end else begin
                            if (r_op == OP_READ) begin
                                out_dcache_read_data <= in_mem_read_data;
                            end
                            out_dcache_ready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_last_grant <= r_grant;
                    r_mask       <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : randomized bench for mem_arbiter with a transaction-timeline
//                  reference model, a fixed-latency memory and directed cases
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int LW        = 128;
    localparam int MEM_LAT   = 10;
    localparam int MEM_WORDS = 8192;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_icache_read_en = 1'b0;
    logic [AW-1:0]  in_icache_addr = '0;
    logic [LW-1:0]  out_icache_read_data;
    logic           out_icache_ready;
    logic           in_dcache_read_en = 1'b0;
    logic           in_dcache_write_en = 1'b0;
    logic [AW-1:0]  in_dcache_addr = '0;
    logic [LW-1:0]  in_dcache_write_data = '0;
    logic [LW-1:0]  out_dcache_read_data;
    logic           out_dcache_ready;
    logic           out_mem_read_en;
    logic           out_mem_write_en;
    logic [AW-1:0]  out_mem_addr;
    logic [LW-1:0]  out_mem_write_data;
    logic [LW-1:0]  in_mem_read_data = '0;
    logic           in_mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_icache_read_en    (in_icache_read_en),
        .in_icache_addr       (in_icache_addr),
        .out_icache_read_data (out_icache_read_data),
        .out_icache_ready     (out_icache_ready),
        .in_dcache_read_en    (in_dcache_read_en),
        .in_dcache_write_en   (in_dcache_write_en),
        .in_dcache_addr       (in_dcache_addr),
        .in_dcache_write_data (in_dcache_write_data),
        .out_dcache_read_data (out_dcache_read_data),
        .out_dcache_ready     (out_dcache_ready),
        .out_mem_read_en      (out_mem_read_en),
        .out_mem_write_en     (out_mem_write_en),
        .out_mem_addr         (out_mem_addr),
        .out_mem_write_data   (out_mem_write_data),
        .in_mem_read_data     (in_mem_read_data),
        .in_mem_ready         (in_mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, exp);
        end
    endtask

    // Deterministic preload pattern so directed expectations are computable.
    function automatic logic [31:0] pre_word(input int w);
        return 32'h1357_0000 + 32'(w) * 32'h0001_0203;
    endfunction

    function automatic logic [127:0] pre_line(input int w0);
        return {pre_word(w0 + 3), pre_word(w0 + 2), pre_word(w0 + 1), pre_word(w0)};
    endfunction

    // ---------------- memory: fixed latency, one ready pulse ----------------
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pl_en = 1'b0;
    logic [12:0] pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          m_cnt;
    logic [10:0] m_line;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (reset) begin
            m_cnt        <= 0;
            in_mem_ready <= 1'b0;
        end else begin
            in_mem_ready <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    in_mem_ready     <= 1'b1;
                    in_mem_read_data <= {mem[{m_line, 2'd3}], mem[{m_line, 2'd2}],
                                         mem[{m_line, 2'd1}], mem[{m_line, 2'd0}]};
                end
            end else if (out_mem_read_en || out_mem_write_en) begin
                m_line <= out_mem_addr[14:4];
                m_cnt  <= MEM_LAT;
                if (out_mem_write_en) begin
                    mem[{out_mem_addr[14:4], 2'd0}] <= out_mem_write_data[31:0];
                    mem[{out_mem_addr[14:4], 2'd1}] <= out_mem_write_data[63:32];
                    mem[{out_mem_addr[14:4], 2'd2}] <= out_mem_write_data[95:64];
                    mem[{out_mem_addr[14:4], 2'd3}] <= out_mem_write_data[127:96];
                end
            end
        end
    end

    // ---------------- reference model: transaction timeline ----------------
    // A granted transaction occupies L+4 cycles: strobe at +1, memory busy,
    // ready at +L+3, then one IDLE cycle in which the served side is masked.
    logic [31:0]  ref_mem [0:MEM_WORDS-1];
    bit           mdl_valid = 0;
    bit           exp_rd, exp_wr, exp_ir, exp_dr, chk_addr, chk_wd;
    logic [127:0] exp_idata, exp_ddata, exp_wdata;
    logic [31:0]  exp_addr;
    bit           m_busy, m_gnt_d, m_write, m_last_d, m_mask_v, m_mask_d;
    bit           want_i, want_d;
    int           m_phase;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        int b;
        b = int'(a[14:4]) * 4;
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    initial begin
        m_busy = 0; m_last_d = 1; m_mask_v = 0; m_mask_d = 0; m_phase = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (pl_en) ref_mem[pl_idx] = pl_val;
            exp_rd = 0; exp_wr = 0; exp_ir = 0; exp_dr = 0;
            if (reset) begin
                mdl_valid = 1;
                m_busy = 0; m_last_d = 1; m_mask_v = 0;
                exp_idata = '0; exp_ddata = '0; exp_addr = '0; exp_wdata = '0;
                chk_addr = 1; chk_wd = 1;
            end else if (!m_busy) begin
                want_i = in_icache_read_en && !(m_mask_v && !m_mask_d);
                want_d = (in_dcache_read_en || in_dcache_write_en) && !(m_mask_v && m_mask_d);
                m_mask_v = 0;
                if (want_i || want_d) begin
                    if (want_i && want_d) m_gnt_d = !m_last_d;
                    else                  m_gnt_d = want_d;
                    m_write = m_gnt_d && in_dcache_write_en;
                    m_addr  = m_gnt_d ? in_dcache_addr : in_icache_addr;
                    m_wdata = in_dcache_write_data;
                    m_busy  = 1;
                    m_phase = 1;
                    exp_rd = !m_write; exp_wr = m_write;
                    exp_addr = m_addr; exp_wdata = m_wdata;
                    chk_addr = 1; chk_wd = m_write;
                end else begin
                    chk_addr = 0; chk_wd = 0;
                end
            end else begin
                if (m_phase == 1 && m_write) begin
                    for (int k = 0; k < 4; k++)
                        ref_mem[int'(m_addr[14:4]) * 4 + k] = m_wdata[32*k +: 32];
                end
                m_phase++;
                if (m_phase == MEM_LAT + 3) begin
                    chk_addr = 0; chk_wd = 0;
                    if (m_gnt_d) begin
                        exp_dr = 1;
                        if (!m_write) exp_ddata = ref_line(m_addr);
                    end else begin
                        exp_ir = 1;
                        exp_idata = ref_line(m_addr);
                    end
                end else if (m_phase == MEM_LAT + 4) begin
                    m_busy = 0; m_last_d = m_gnt_d;
                    m_mask_v = 1; m_mask_d = m_gnt_d;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("mem_read_en", 128'(out_mem_read_en), 128'(exp_rd));
            check("mem_write_en", 128'(out_mem_write_en), 128'(exp_wr));
            check("icache_ready", 128'(out_icache_ready), 128'(exp_ir));
            check("dcache_ready", 128'(out_dcache_ready), 128'(exp_dr));
            check("icache_data", out_icache_read_data, exp_idata);
            check("dcache_data", out_dcache_read_data, exp_ddata);
            if (chk_addr) check("mem_addr", 128'(out_mem_addr), 128'(exp_addr));
            if (chk_wd) check("mem_wdata", out_mem_write_data, exp_wdata);
        end
    end

    // ---------------- stimulus ----------------
    bit i_req = 0, d_req = 0;
    int i_drop = 0, d_drop = 0;

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 13'(idx); pl_val = val;
    endtask

    task automatic wait_ready(input bit d_side, input int limit, output int at);
        at = -1000;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (d_side ? out_dcache_ready : out_icache_ready) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"}, 128'(out_mem_read_en), 128'(0));
        check({tag, "_wr"}, 128'(out_mem_write_en), 128'(0));
        check({tag, "_iready"}, 128'(out_icache_ready), 128'(0));
        check({tag, "_dready"}, 128'(out_dcache_ready), 128'(0));
        check({tag, "_addr"}, 128'(out_mem_addr), 128'(0));
        check({tag, "_wdata"}, out_mem_write_data, 128'(0));
        check({tag, "_idata"}, out_icache_read_data, 128'(0));
        check({tag, "_ddata"}, out_dcache_read_data, 128'(0));
    endtask

    // Level-held requesters; a third of the time the enable lingers one
    // cycle past the ready pulse.
    task automatic drive_random(input bit allow_new);
        @(negedge clk);
        if (i_req && out_icache_ready) i_drop = ($urandom_range(0, 2) == 0) ? cyc + 2 : cyc;
        if (i_req && cyc >= i_drop) begin
            i_req = 0; in_icache_read_en = 1'b0;
        end else if (!i_req && allow_new && $urandom_range(0, 3) == 0) begin
            i_req = 1; i_drop = 32'h7fff_ffff;
            in_icache_addr = 32'($urandom_range(0, 63)) << 4;
            in_icache_read_en = 1'b1;
        end
        if (d_req && out_dcache_ready) d_drop = ($urandom_range(0, 2) == 0) ? cyc + 2 : cyc;
        if (d_req && cyc >= d_drop) begin
            d_req = 0; in_dcache_read_en = 1'b0; in_dcache_write_en = 1'b0;
        end else if (!d_req && allow_new && $urandom_range(0, 3) == 0) begin
            int op;
            op = int'($urandom_range(0, 3));
            d_req = 1; d_drop = 32'h7fff_ffff;
            in_dcache_addr = 32'($urandom_range(0, 63)) << 4;
            in_dcache_write_data = {$urandom, $urandom, $urandom, $urandom};
            in_dcache_read_en  = (op != 2);
            in_dcache_write_en = (op >= 2);
        end
    endtask

    initial begin
        int t0, at, rd_n, wr_n, strb;
        for (int w = 0; w < 256; w++) preload(w, pre_word(w));
        preload(13'h400, 32'h0500_8093);
        preload(13'h401, 32'h0000_9073);
        preload(13'h402, 32'h1020_0073);
        preload(13'h403, 32'h0000_0000);
        @(negedge clk);
        pl_en = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Simultaneous I and D reads: I wins the first tie, D follows L+4 later.
        repeat (2) @(negedge clk);
        in_icache_read_en = 1'b1; in_icache_addr = 32'h40;
        in_dcache_read_en = 1'b1; in_dcache_addr = 32'h80;
        t0 = cyc;
        wait_ready(1'b0, 40, at);
        check("tie_i_latency", 128'(at - t0), 128'(13));
        check("tie_d_not_ready", 128'(out_dcache_ready), 128'(0));
        check("tie_i_data", out_icache_read_data, pre_line(32'h10));
        in_icache_read_en = 1'b0;
        wait_ready(1'b1, 40, at);
        check("tie_d_latency", 128'(at - t0), 128'(27));
        check("tie_d_data", out_dcache_read_data, pre_line(32'h20));
        in_dcache_read_en = 1'b0;

        // Lone I read with enable held one cycle past ready.
        repeat (3) @(negedge clk);
        in_icache_read_en = 1'b1; in_icache_addr = 32'h1000;
        t0 = cyc;
        @(negedge clk);
        check("lone_strobe", 128'(out_mem_read_en), 128'(1));
        check("lone_addr", 128'(out_mem_addr), 128'(32'h1000));
        wait_ready(1'b0, 40, at);
        check("lone_latency", 128'(at - t0), 128'(13));
        check("lone_data", out_icache_read_data,
              128'h00000000_10200073_00009073_05008093);
        check("lone_d_quiet", 128'(out_dcache_ready), 128'(0));
        strb = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) in_icache_read_en = 1'b0;
            if (out_mem_read_en || out_mem_write_en) strb++;
        end
        check("hold_no_regrant", 128'(strb), 128'(0));

        // D write with both enables high, then read back.
        repeat (2) @(negedge clk);
        in_dcache_read_en = 1'b1; in_dcache_write_en = 1'b1; in_dcache_addr = 32'h200;
        in_dcache_write_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        t0 = cyc; rd_n = 0; wr_n = 0; at = -1000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_mem_read_en) rd_n++;
            if (out_mem_write_en) wr_n++;
            if (out_dcache_ready) begin at = cyc; break; end
        end
        check("wr_latency", 128'(at - t0), 128'(13));
        check("wr_read_strobes", 128'(rd_n), 128'(0));
        check("wr_write_strobes", 128'(wr_n), 128'(1));
        check("wr_ddata_kept", out_dcache_read_data, pre_line(32'h20));
        in_dcache_read_en = 1'b0; in_dcache_write_en = 1'b0;
        repeat (3) @(negedge clk);
        in_dcache_read_en = 1'b1; in_dcache_addr = 32'h200;
        t0 = cyc;
        wait_ready(1'b1, 40, at);
        check("rb_latency", 128'(at - t0), 128'(13));
        check("rb_data", out_dcache_read_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        in_dcache_read_en = 1'b0;

        // Reset while waiting on memory abandons the read.
        repeat (3) @(negedge clk);
        in_icache_read_en = 1'b1; in_icache_addr = 32'h300;
        t0 = cyc;
        repeat (6) @(negedge clk);
        reset = 1'b1; in_icache_read_en = 1'b0;
        @(negedge clk);
        check_all_zero("wait_reset");
        reset = 1'b0;
        strb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_icache_ready || out_dcache_ready) strb++;
        end
        check("abandon_no_ready", 128'(strb), 128'(0));
        in_icache_read_en = 1'b1; in_icache_addr = 32'h1000;
        t0 = cyc;
        wait_ready(1'b0, 40, at);
        check("post_reset_latency", 128'(at - t0), 128'(13));
        check("post_reset_data", out_icache_read_data,
              128'h00000000_10200073_00009073_05008093);
        in_icache_read_en = 1'b0;
        repeat (3) @(negedge clk);

        for (int n = 0; n < 4000; n++) drive_random(1'b1);
        for (int n = 0; n < 300 && (i_req || d_req); n++) drive_random(1'b0);
        check("drain_idle", 128'({i_req, d_req}), 128'(0));
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
